// File: rtl/epbuf_arb_pkg.sv
// Shared EP buffer port widths and the per-requester port bundle used by the arbiter.
package epbuf_arb_pkg;

  localparam int EP_TX_AW = 8;
  localparam int EP_RX_AW = 9;
  localparam int EP_DW    = 16;
  localparam int EP_MW    = 2;

  typedef struct packed {
    logic                req;
    logic [EP_TX_AW-1:0] tx_addr;
    logic [EP_DW-1:0]    tx_data;
    logic [EP_MW-1:0]    tx_wmsk;
    logic                tx_we;
    logic [EP_RX_AW-1:0] rx_addr;
    logic                rx_re;
  } ep_req_t;

endpackage

// File: rtl/epbuf_arb_rr.sv
// Two-way round-robin pick: a lone requester wins outright, and on contention
// the requester that was not served last wins.
module epbuf_arb_rr (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       vld_o,
  output logic       pick_o
);

  assign vld_o  = |req_i;
  assign pick_o = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/epbuf_arb.sv
// Locked-grant round-robin arbiter for the shared EP buffer TX-write / RX-read port.
// Optional burst preemption is built when EPBUF_ARB_BURST_LIMIT_EN is defined.
module epbuf_arb
  import epbuf_arb_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         r0_req,
  output logic                         r0_gnt,
  input  logic [EP_TX_AW-1:0]          r0_tx_addr,
  input  logic [EP_DW-1:0]             r0_tx_data,
  input  logic [EP_MW-1:0]             r0_tx_wmsk,
  input  logic                         r0_tx_we,
  input  logic [EP_RX_AW-1:0]          r0_rx_addr,
  input  logic                         r0_rx_re,
  output logic [EP_DW-1:0]             r0_rx_data,
  output logic                         r0_rx_vld,
  input  logic                         r1_req,
  output logic                         r1_gnt,
  input  logic [EP_TX_AW-1:0]          r1_tx_addr,
  input  logic [EP_DW-1:0]             r1_tx_data,
  input  logic [EP_MW-1:0]             r1_tx_wmsk,
  input  logic                         r1_tx_we,
  input  logic [EP_RX_AW-1:0]          r1_rx_addr,
  input  logic                         r1_rx_re,
  output logic [EP_DW-1:0]             r1_rx_data,
  output logic                         r1_rx_vld,
  output logic [EP_TX_AW-1:0]          ep_tx_addr_0,
  output logic [EP_DW-1:0]             ep_tx_data_0,
  output logic [EP_MW-1:0]             ep_tx_wmsk_0,
  output logic                         ep_tx_we_0,
  output logic [EP_RX_AW-1:0]          ep_rx_addr_0,
  output logic                         ep_rx_re_0,
  input  logic [EP_DW-1:0]             ep_rx_data_1,
  output logic [1:0]                   dbg_state_o,
  output logic [$clog2(MAX_BURST)-1:0] dbg_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  localparam int CW = $clog2(MAX_BURST);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] rx_vld_q, rx_vld_d;
  logic       pick_vld, pick;
  logic       preempt;
  logic       own_gnt;
  ep_req_t    rq0, rq1, own;

  assign rq0 = {r0_req, r0_tx_addr, r0_tx_data, r0_tx_wmsk, r0_tx_we, r0_rx_addr, r0_rx_re};
  assign rq1 = {r1_req, r1_tx_addr, r1_tx_data, r1_tx_wmsk, r1_tx_we, r1_rx_addr, r1_rx_re};

  epbuf_arb_rr u_rr (
    .req_i  ({r1_req, r0_req}),
    .last_i (last_q),
    .vld_o  (pick_vld),
    .pick_o (pick)
  );

`ifdef EPBUF_ARB_BURST_LIMIT_EN
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign preempt   = (cnt_q == CNT_MAX);
  assign dbg_cnt_o = cnt_q;

  // Counter restarts on every state entry so each new owner gets a full burst.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (own_gnt && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign preempt   = 1'b0;
  assign dbg_cnt_o = '0;
`endif

  // Handshake: a requester raises req and holds it for its whole transaction; it may
  // only strobe while gnt is high. Dropping req releases the port at the next edge.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) state_d = pick ? ST_OWN1 : ST_OWN0;
      end
      ST_OWN0: begin
        if (r1_req && (!r0_req || preempt)) state_d = ST_OWN1;
        else if (!r0_req)                   state_d = ST_IDLE;
      end
      ST_OWN1: begin
        if (r0_req && (!r1_req || preempt)) state_d = ST_OWN0;
        else if (!r1_req)                   state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_OWN0) last_d = 1'b0;
    if (state_d == ST_OWN1) last_d = 1'b1;
  end

  assign own_gnt = (state_q == ST_OWN0) || (state_q == ST_OWN1);
  assign own     = (state_q == ST_OWN1) ? rq1 : rq0;

  always_comb begin
    ep_tx_addr_0 = '0;
    ep_tx_data_0 = '0;
    ep_tx_wmsk_0 = '0;
    ep_tx_we_0   = 1'b0;
    ep_rx_addr_0 = '0;
    ep_rx_re_0   = 1'b0;
    if (own_gnt) begin
      ep_tx_addr_0 = own.tx_addr;
      ep_tx_data_0 = own.tx_data;
      ep_tx_wmsk_0 = own.tx_wmsk;
      ep_tx_we_0   = own.tx_we & own.req & own_gnt;
      ep_rx_addr_0 = own.rx_addr;
      ep_rx_re_0   = own.rx_re & own.req & own_gnt;
    end
  end

  // Read valid follows the issuer, so a read completes even if ownership moves.
  assign rx_vld_d = {(state_q == ST_OWN1) & ep_rx_re_0, (state_q == ST_OWN0) & ep_rx_re_0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      rx_vld_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rx_vld_q <= rx_vld_d;
    end
  end

  assign r0_gnt      = (state_q == ST_OWN0);
  assign r1_gnt      = (state_q == ST_OWN1);
  assign r0_rx_vld   = rx_vld_q[0];
  assign r1_rx_vld   = rx_vld_q[1];
  assign r0_rx_data  = ep_rx_data_1;
  assign r1_rx_data  = ep_rx_data_1;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_epbuf_arb.sv
// Self-checking bench for epbuf_arb: directed scenarios plus a randomized run against
// a reference grant model; TX writes and RX reads are scoreboarded through expected queues.
module tb_epbuf_arb;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_req, r0_tx_we, r0_rx_re, r1_req, r1_tx_we, r1_rx_re;
  logic [7:0]  r0_tx_addr, r1_tx_addr;
  logic [15:0] r0_tx_data, r1_tx_data;
  logic [1:0]  r0_tx_wmsk, r1_tx_wmsk;
  logic [8:0]  r0_rx_addr, r1_rx_addr;
  logic        r0_gnt, r1_gnt, r0_rx_vld, r1_rx_vld;
  logic [15:0] r0_rx_data, r1_rx_data;
  logic [7:0]  ep_tx_addr_0;
  logic [15:0] ep_tx_data_0;
  logic [1:0]  ep_tx_wmsk_0;
  logic        ep_tx_we_0, ep_rx_re_0;
  logic [8:0]  ep_rx_addr_0;
  logic [15:0] ep_rx_data_1 = '0;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_cnt;

  logic [25:0] exp_tx_q[$];
  logic [15:0] exp_rx0_q[$];
  logic [15:0] exp_rx1_q[$];
  int checks = 0;
  int errors = 0;

  int m_state, m_last, m_cnt;

  epbuf_arb #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_gnt(r0_gnt), .r0_tx_addr(r0_tx_addr), .r0_tx_data(r0_tx_data),
    .r0_tx_wmsk(r0_tx_wmsk), .r0_tx_we(r0_tx_we), .r0_rx_addr(r0_rx_addr), .r0_rx_re(r0_rx_re),
    .r0_rx_data(r0_rx_data), .r0_rx_vld(r0_rx_vld),
    .r1_req(r1_req), .r1_gnt(r1_gnt), .r1_tx_addr(r1_tx_addr), .r1_tx_data(r1_tx_data),
    .r1_tx_wmsk(r1_tx_wmsk), .r1_tx_we(r1_tx_we), .r1_rx_addr(r1_rx_addr), .r1_rx_re(r1_rx_re),
    .r1_rx_data(r1_rx_data), .r1_rx_vld(r1_rx_vld),
    .ep_tx_addr_0(ep_tx_addr_0), .ep_tx_data_0(ep_tx_data_0), .ep_tx_wmsk_0(ep_tx_wmsk_0),
    .ep_tx_we_0(ep_tx_we_0), .ep_rx_addr_0(ep_rx_addr_0), .ep_rx_re_0(ep_rx_re_0),
    .ep_rx_data_1(ep_rx_data_1), .dbg_state_o(dbg_state), .dbg_cnt_o(dbg_cnt)
  );

  // Clock / EP buffer read model
  always #5 clk = ~clk;

  function automatic logic [15:0] rd_val(input logic [8:0] a);
    return {a[7:0], a[8], 7'h2B} ^ 16'h3C5A;
  endfunction

  always @(posedge clk) ep_rx_data_1 <= rd_val(ep_rx_addr_0);

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [25:0] et;
    logic [15:0] er;
    if (ep_tx_we_0 === 1'b1) begin
      checks++;
      if (exp_tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got addr=%h data=%h wmsk=%b, no write expected", ep_tx_addr_0, ep_tx_data_0, ep_tx_wmsk_0);
      end else begin
        et = exp_tx_q.pop_front();
        if ({ep_tx_addr_0, ep_tx_data_0, ep_tx_wmsk_0} !== et) begin
          errors++;
          $display("FAIL tx_write: got %h exp %h", {ep_tx_addr_0, ep_tx_data_0, ep_tx_wmsk_0}, et);
        end
      end
    end
    if (r0_rx_vld === 1'b1) begin
      checks++;
      if (exp_rx0_q.size() == 0) begin
        errors++;
        $display("FAIL rx0_unexpected: got vld with data %h, none expected", r0_rx_data);
      end else begin
        er = exp_rx0_q.pop_front();
        if (r0_rx_data !== er) begin errors++; $display("FAIL rx0_data: got %h exp %h", r0_rx_data, er); end
      end
    end
    if (r1_rx_vld === 1'b1) begin
      checks++;
      if (exp_rx1_q.size() == 0) begin
        errors++;
        $display("FAIL rx1_unexpected: got vld with data %h, none expected", r1_rx_data);
      end else begin
        er = exp_rx1_q.pop_front();
        if (r1_rx_data !== er) begin errors++; $display("FAIL rx1_data: got %h exp %h", r1_rx_data, er); end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    r0_req = 0; r0_tx_we = 0; r0_rx_re = 0; r0_tx_addr = '0; r0_tx_data = '0; r0_tx_wmsk = '0; r0_rx_addr = '0;
    r1_req = 0; r1_tx_we = 0; r1_rx_re = 0; r1_tx_addr = '0; r1_tx_data = '0; r1_tx_wmsk = '0; r1_rx_addr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    @(negedge clk);
    checks++; if (r0_gnt !== 1'b0) begin errors++; $display("FAIL reset_r0_gnt: got %b exp 0", r0_gnt); end
    checks++; if (r1_gnt !== 1'b0) begin errors++; $display("FAIL reset_r1_gnt: got %b exp 0", r1_gnt); end
    checks++; if ({r1_rx_vld, r0_rx_vld} !== 2'b00) begin errors++; $display("FAIL reset_rx_vld: got %b exp 00", {r1_rx_vld, r0_rx_vld}); end
    checks++; if ({ep_tx_we_0, ep_rx_re_0, ep_tx_addr_0} !== 10'h0) begin errors++; $display("FAIL reset_ep_out: got %h exp 0", {ep_tx_we_0, ep_rx_re_0, ep_tx_addr_0}); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    r0_req = 1;
    @(negedge clk);
    checks++; if (r0_gnt !== 1'b0) begin errors++; $display("FAIL t1_gnt_latency: got %b exp 0", r0_gnt); end
    step();
    r0_tx_addr = 8'h12; r0_tx_data = 16'hBEEF; r0_tx_wmsk = 2'b11; r0_tx_we = 1;
    exp_tx_q.push_back({8'h12, 16'hBEEF, 2'b11});
    @(negedge clk);
    checks++; if (r0_gnt !== 1'b1) begin errors++; $display("FAIL t1_gnt: got %b exp 1", r0_gnt); end
    checks++; if (ep_tx_we_0 !== 1'b1) begin errors++; $display("FAIL t1_we: got %b exp 1", ep_tx_we_0); end
    step();
    r0_tx_we = 0; r0_req = 0;
    @(negedge clk);
    checks++; if (r0_gnt !== 1'b1) begin errors++; $display("FAIL t1_gnt_hold: got %b exp 1", r0_gnt); end
    step();
    @(negedge clk);
    checks++; if (r0_gnt !== 1'b0) begin errors++; $display("FAIL t1_gnt_drop: got %b exp 0", r0_gnt); end
    checks++; if (ep_tx_addr_0 !== 8'h00) begin errors++; $display("FAIL t1_idle_addr: got %h exp 00", ep_tx_addr_0); end
    step();
  endtask

  task automatic test_contention();
    do_reset();
    r0_req = 1; r1_req = 1;
    step();
    @(negedge clk);
    checks++; if ({r1_gnt, r0_gnt} !== 2'b01) begin errors++; $display("FAIL t2_first_win: got %b exp 01", {r1_gnt, r0_gnt}); end
    step();
    r0_req = 0;
    @(negedge clk);
    checks++; if ({r1_gnt, r0_gnt} !== 2'b01) begin errors++; $display("FAIL t2_hold: got %b exp 01", {r1_gnt, r0_gnt}); end
    step();
    @(negedge clk);
    checks++; if ({r1_gnt, r0_gnt} !== 2'b10) begin errors++; $display("FAIL t2_handoff: got %b exp 10", {r1_gnt, r0_gnt}); end
    step();
  endtask

  task automatic test_nonowner_read();
    r0_req = 1; r0_rx_re = 1; r0_rx_addr = 9'h040;
    @(negedge clk);
    checks++; if (ep_rx_re_0 !== 1'b0) begin errors++; $display("FAIL t3_nonowner_re: got %b exp 0", ep_rx_re_0); end
    checks++; if (r1_gnt !== 1'b1) begin errors++; $display("FAIL t3_r1_keeps: got %b exp 1", r1_gnt); end
    step();
    r0_rx_re = 0; r1_rx_re = 1; r1_rx_addr = 9'h040;
    exp_rx1_q.push_back(rd_val(9'h040));
    @(negedge clk);
    checks++; if ({ep_rx_re_0, ep_rx_addr_0} !== {1'b1, 9'h040}) begin errors++; $display("FAIL t3_owner_re: got %h exp 240", {ep_rx_re_0, ep_rx_addr_0}); end
    step();
    r1_rx_re = 0;
    @(negedge clk);
    checks++; if ({r1_rx_vld, r0_rx_vld} !== 2'b10) begin errors++; $display("FAIL t3_vld: got %b exp 10", {r1_rx_vld, r0_rx_vld}); end
    checks++; if (r1_rx_data !== rd_val(9'h040)) begin errors++; $display("FAIL t3_data: got %h exp %h", r1_rx_data, rd_val(9'h040)); end
    step();
  endtask

  task automatic test_read_then_drop();
    r1_rx_re = 1; r1_rx_addr = 9'h155;
    exp_rx1_q.push_back(rd_val(9'h155));
    step();
    r1_req = 0; r1_rx_re = 0;
    @(negedge clk);
    checks++; if ({r1_rx_vld, r1_gnt, ep_rx_re_0} !== 3'b110) begin errors++; $display("FAIL t4_last_read: got %b exp 110", {r1_rx_vld, r1_gnt, ep_rx_re_0}); end
    step();
    @(negedge clk);
    checks++; if ({r1_gnt, r0_gnt, r1_rx_vld} !== 3'b010) begin errors++; $display("FAIL t4_handoff: got %b exp 010", {r1_gnt, r0_gnt, r1_rx_vld}); end
    step();
    r0_req = 0;
    step();
  endtask

  task automatic test_burst_limit();
    int n;
    n = 0;
    do_reset();
    r0_req = 1;
    step();
    r1_req = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (r0_gnt !== 1'b1) break;
      n++;
      step();
    end
`ifdef EPBUF_ARB_BURST_LIMIT_EN
    checks++; if (n !== MAXB) begin errors++; $display("FAIL t5_burst_len: got %0d exp %0d", n, MAXB); end
    checks++; if (r1_gnt !== 1'b1) begin errors++; $display("FAIL t5_preempt_gnt: got %b exp 1", r1_gnt); end
`else
    checks++; if (n !== 12) begin errors++; $display("FAIL t5_no_preempt_len: got %0d exp 12", n); end
    @(negedge clk);
    checks++; if ({r1_gnt, r0_gnt} !== 2'b01) begin errors++; $display("FAIL t5_no_preempt_gnt: got %b exp 01", {r1_gnt, r0_gnt}); end
`endif
    step();
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    r0_req = 1;
    step();
    r0_tx_addr = 8'h7E; r0_tx_data = 16'h1234; r0_tx_wmsk = 2'b01; r0_tx_we = 1;
    r0_rx_addr = 9'h1AB; r0_rx_re = 1; r1_req = 1; rst = 1;
    exp_tx_q.push_back({8'h7E, 16'h1234, 2'b01});
    @(negedge clk);
    checks++; if (ep_tx_we_0 !== 1'b1) begin errors++; $display("FAIL t6_pre_we: got %b exp 1", ep_tx_we_0); end
    step();
    rst = 0;
    @(negedge clk);
    checks++; if ({r1_gnt, r0_gnt} !== 2'b00) begin errors++; $display("FAIL t6_gnt: got %b exp 00", {r1_gnt, r0_gnt}); end
    checks++; if ({ep_tx_we_0, ep_rx_re_0} !== 2'b00) begin errors++; $display("FAIL t6_strobes: got %b exp 00", {ep_tx_we_0, ep_rx_re_0}); end
    checks++; if ({r1_rx_vld, r0_rx_vld} !== 2'b00) begin errors++; $display("FAIL t6_vld: got %b exp 00", {r1_rx_vld, r0_rx_vld}); end
    step();
    r0_tx_we = 0; r0_rx_re = 0;
    @(negedge clk);
    checks++; if ({r1_gnt, r0_gnt} !== 2'b01) begin errors++; $display("FAIL t6_post_win: got %b exp 01", {r1_gnt, r0_gnt}); end
    clear_inputs();
    step();
    step();
  endtask

  task automatic model_next();
    int nxt;
    nxt = m_state;
    case (m_state)
      0: begin
        if (r0_req && r1_req) nxt = (m_last == 1) ? 1 : 2;
        else if (r0_req)      nxt = 1;
        else if (r1_req)      nxt = 2;
      end
      1: begin
        if (!r0_req) nxt = r1_req ? 2 : 0;
`ifdef EPBUF_ARB_BURST_LIMIT_EN
        else if (r1_req && m_cnt == MAXB - 1) nxt = 2;
`endif
      end
      default: begin
        if (!r1_req) nxt = r0_req ? 1 : 0;
`ifdef EPBUF_ARB_BURST_LIMIT_EN
        else if (r0_req && m_cnt == MAXB - 1) nxt = 1;
`endif
      end
    endcase
    if (nxt != m_state) m_cnt = 0;
    else if (m_state != 0 && m_cnt < MAXB - 1) m_cnt++;
    if (nxt == 1) m_last = 0;
    if (nxt == 2) m_last = 1;
    m_state = nxt;
  endtask

  task automatic test_random();
    do_reset();
    m_state = 0; m_last = 1; m_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      r0_req = r0_req ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      r1_req = r1_req ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      r0_tx_we = 1'($urandom_range(0, 1)); r0_tx_addr = 8'($urandom_range(0, 255));
      r0_tx_data = 16'($urandom); r0_tx_wmsk = 2'($urandom_range(0, 3));
      r0_rx_re = 1'($urandom_range(0, 1)); r0_rx_addr = 9'($urandom_range(0, 511));
      r1_tx_we = 1'($urandom_range(0, 1)); r1_tx_addr = 8'($urandom_range(0, 255));
      r1_tx_data = 16'($urandom); r1_tx_wmsk = 2'($urandom_range(0, 3));
      r1_rx_re = 1'($urandom_range(0, 1)); r1_rx_addr = 9'($urandom_range(0, 511));
      if (m_state == 1 && r0_req && r0_tx_we) exp_tx_q.push_back({r0_tx_addr, r0_tx_data, r0_tx_wmsk});
      if (m_state == 1 && r0_req && r0_rx_re) exp_rx0_q.push_back(rd_val(r0_rx_addr));
      if (m_state == 2 && r1_req && r1_tx_we) exp_tx_q.push_back({r1_tx_addr, r1_tx_data, r1_tx_wmsk});
      if (m_state == 2 && r1_req && r1_rx_re) exp_rx1_q.push_back(rd_val(r1_rx_addr));
      @(negedge clk);
      checks++;
      if ({r1_gnt, r0_gnt} !== {1'(m_state == 2), 1'(m_state == 1)}) begin
        errors++;
        $display("FAIL rand_gnt cycle %0d: got %b exp %b", i, {r1_gnt, r0_gnt}, {1'(m_state == 2), 1'(m_state == 1)});
      end
      model_next();
      step();
    end
    clear_inputs();
    step();
    step();
    step();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_contention();
    test_nonowner_read();
    test_read_then_drop();
    test_burst_limit();
    test_reset_mid_write();
    test_random();
    @(negedge clk);
    checks++;
    if (exp_tx_q.size() + exp_rx0_q.size() + exp_rx1_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d/%0d pending exp 0/0/0", exp_tx_q.size(), exp_rx0_q.size(), exp_rx1_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
